// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types for the iterative multiply/divide unit
// Purpose: operation codes issued from Execute and the sequencer state encoding.
// Ports: none (package).
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - Execute/Decode side bundle of the multiply/divide unit
// Purpose: groups the op issue, hazard and HI/LO result signals.
// Ports (master = pipeline side, slave = muldiv unit):
//   startE, opE, srcaE, srcbE, flushE, hiloreqD  pipeline -> unit
//   stallMD, busy, done, hi, lo                  unit -> pipeline
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             startE;
  muldiv_op_t       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             flushE;
  logic             hiloreqD;
  logic             stallMD;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, opE, srcaE, srcbE, flushE, hiloreqD,
    input  stallMD, busy, done, hi, lo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, flushE, hiloreqD,
    output stallMD, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide datapath
// Purpose: 2*WIDTH accumulator (product, or {remainder, quotient}), operand
//   register, shared WIDTH+1-bit add/subtract and final sign correction.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load, step        load magnitudes / perform one iteration
//   is_div            selects divide behaviour for load, step and result
//   op_a, op_b        operand magnitudes (a = multiplicand/dividend, b = multiplier/divisor)
//   neg_hi, neg_lo    negate the corresponding result half (multiply uses neg_lo for all 2*WIDTH bits)
//   res_hi, res_lo    sign-corrected results, valid in the FIX cycle
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             neg_hi,
  input  logic             neg_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mreg_q;

  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH+1:0]   alu_y;
  logic               borrow;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Divide: {rem, next dividend bit} is the trial minuend.
  assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
  // Multiply: add the multiplicand only when the multiplier LSB is set.
  assign addend  = acc_q[0] ? mreg_q : '0;

  always_comb begin
    if (is_div) begin
      alu_y = {1'b0, shifted} - {2'b00, mreg_q};
    end else begin
      alu_y = {2'b00, acc_q[2*WIDTH-1:WIDTH]} + {2'b00, addend};
    end
  end

  assign borrow = alu_y[WIDTH+1];

  always_comb begin
    if (is_div) begin
      // Restore on borrow; the quotient bit enters at the LSB.
      acc_next = {(borrow ? shifted[WIDTH-1:0] : alu_y[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], ~borrow};
    end else begin
      // Carry out of the add becomes the new MSB as the pair shifts right.
      acc_next = {alu_y[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      mreg_q <= '0;
    end else if (load) begin
      acc_q  <= {{WIDTH{1'b0}}, (is_div ? op_a : op_b)};
      mreg_q <= is_div ? op_b : op_a;
    end else if (step) begin
      acc_q  <= acc_next;
    end
  end

  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_lo ? ('0 - acc_q) : acc_q;

  always_comb begin
    if (is_div) begin
      res_lo = neg_lo ? ('0 - quo) : quo;
      res_hi = neg_hi ? ('0 - rem) : rem;
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multiply/divide sequencer and HI/LO owner for Execute
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs WIDTH iterations plus a
//   FIX cycle on the datapath, writes HI/LO and requests a stall while busy.
// Ports:
//   clk, reset   clock, synchronous active-high reset (aborts any operation)
//   bus          muldiv_sequencer_if.slave: startE, opE, srcaE, srcbE, flushE,
//                hiloreqD in; stallMD, busy, done, hi, lo out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    count_q;
  logic             sa_q, sb_q, div_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             accept, op_mul, op_div, op_signed, b_zero;
  logic             sa_d, sb_d;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             load, step, fix_wr;
  logic             dp_div, neg_hi, neg_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign accept    = bus.startE & ~bus.flushE & (state_q == IDLE);
  assign op_mul    = (bus.opE == MD_MULT) | (bus.opE == MD_MULTU);
  assign op_div    = (bus.opE == MD_DIV)  | (bus.opE == MD_DIVU);
  assign op_signed = (bus.opE == MD_MULT) | (bus.opE == MD_DIV);
  assign b_zero    = (bus.srcbE == '0);

  // Divide by zero runs unsigned with no sign fix so hi ends up as raw srcaE.
  assign sa_d  = op_signed & bus.srcaE[WIDTH-1] & ~(op_div & b_zero);
  assign sb_d  = op_signed & bus.srcbE[WIDTH-1];
  // Negating 0x8000_0000 yields itself, which is its correct unsigned magnitude.
  assign mag_a = sa_d ? ('0 - bus.srcaE) : bus.srcaE;
  assign mag_b = sb_d ? ('0 - bus.srcbE) : bus.srcbE;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && op_mul) begin
          state_d = MUL;
          load    = 1'b1;
        end else if (accept && op_div) begin
          state_d = DIV;
          load    = 1'b1;
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        fix_wr  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        count_q <= '0;
        sa_q    <= sa_d;
        sb_q    <= sb_d;
        div_q   <= op_div;
      end else if (step) begin
        count_q <= count_q + CW'(1);
      end
      if (accept && bus.opE == MD_MTHI) hi_q <= bus.srcaE;
      if (accept && bus.opE == MD_MTLO) lo_q <= bus.srcaE;
      if (fix_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  // The latched mode is stale during the load cycle, so use the incoming op then.
  assign dp_div = load ? op_div : div_q;
  assign neg_lo = sa_q ^ sb_q;
  assign neg_hi = div_q ? sa_q : (sa_q ^ sb_q);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (dp_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .neg_hi (neg_hi),
    .neg_lo (neg_lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FIX);
  assign bus.stallMD = bus.busy & bus.hiloreqD;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule
